// File: rtl/shb_pkg.sv
// Shared shrinked-AHB definitions: FSM state encoding, htrans/hresp codes,
// wait-counter width and a lane-count helper.
// Combinational constants only; no latency, no backpressure.
package shb_pkg;

    // Responder data-phase states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RAW  = 3'd3,
        ERR1 = 3'd4,
        ERR2 = 3'd5
    } shb_state_e;

    localparam logic TRANS_IDLE = 1'b0;
    localparam logic TRANS_ACT  = 1'b1;
    localparam logic RESP_OK    = 1'b0;
    localparam logic RESP_ERR   = 1'b1;

    // Enough for WAIT_STATES in 0..7.
    localparam int WCNT_W = 3;

    // log2 of the number of byte lanes for a given data width.
    function automatic int nb_log2(input int bus_width);
        return $clog2(bus_width / 8);
    endfunction

endpackage

// File: rtl/shb_sram_slave_if.sv
// Shrinked-AHB bus bundle between the core's bus unit (master) and a target (slave).
// Ports: haddr/hwrite/hburst/htrans/hwdata from the master; hready/hresp/hrdata back.
// hready is the only flow control: low stretches the current data phase.
interface shb_sram_slave_if #(
    parameter int BUS_ADDR  = 32,
    parameter int BUS_WIDTH = 16
);
    localparam int NB = BUS_WIDTH / 8;

    logic [BUS_ADDR-1:0]  haddr;
    logic [NB-1:0]        hwrite;
    logic                 hburst;
    logic                 htrans;
    logic [BUS_WIDTH-1:0] hwdata;
    logic                 hready;
    logic                 hresp;
    logic [BUS_WIDTH-1:0] hrdata;

    modport master (
        output haddr, hwrite, hburst, htrans, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, hburst, htrans, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/shb_addr_decode.sv
// Address window hit and SRAM word-index extraction for shrinked-AHB targets.
// Purely combinational, zero latency.
// No backpressure; result is valid whenever haddr_i is.
// Ports: haddr_i byte address; hit_o inside [BASE_ADDR, BASE_ADDR + NB*2^MEM_AW);
//        idx_o word index haddr_i[MEM_AW+log2(NB)-1 : log2(NB)].
module shb_addr_decode
    import shb_pkg::*;
#(
    parameter int                  BUS_ADDR  = 32,
    parameter int                  BUS_WIDTH = 16,
    parameter int                  MEM_AW    = 12,
    parameter logic [BUS_ADDR-1:0] BASE_ADDR = '0
) (
    input  logic [BUS_ADDR-1:0] haddr_i,
    output logic                hit_o,
    output logic [MEM_AW-1:0]   idx_o
);
    localparam int LSB      = nb_log2(BUS_WIDTH);
    localparam int WIN_BITS = MEM_AW + LSB;

    // The window is size-aligned, so a hit is just equal upper bits.
    assign hit_o = (haddr_i >> WIN_BITS) == (BASE_ADDR >> WIN_BITS);
    assign idx_o = MEM_AW'(haddr_i >> LSB);
endmodule

// File: rtl/shb_sram_slave.sv
// Shrinked-AHB responder in front of a single-port synchronous SRAM.
// Latency: data phase ends WAIT_STATES+1 cycles after the address (+1 on read-after-write).
// Backpressure: hready low during wait states, the RAW deferral cycle and ERR1.
// Ports: clk, rst (async, active-high); bus (slave modport of shb_sram_slave_if);
//        mem_ce/mem_we/mem_addr/mem_wdata to the SRAM, mem_rdata back one cycle after mem_ce.
// Build option: SHB_SLAVE_RANGE_CHECK_EN enables the out-of-window error response.
module shb_sram_slave
    import shb_pkg::*;
#(
    parameter int                  BUS_ADDR    = 32,
    parameter int                  BUS_WIDTH   = 16,
    parameter int                  MEM_AW      = 12,
    parameter int                  WAIT_STATES = 0,
    parameter logic [BUS_ADDR-1:0] BASE_ADDR   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    shb_sram_slave_if.slave          bus,
    output logic                     mem_ce,
    output logic [BUS_WIDTH/8-1:0]   mem_we,
    output logic [MEM_AW-1:0]        mem_addr,
    output logic [BUS_WIDTH-1:0]     mem_wdata,
    input  logic [BUS_WIDTH-1:0]     mem_rdata
);
    localparam int NB = BUS_WIDTH / 8;

    shb_state_e           state_q, state_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic [MEM_AW-1:0]    addr_q, addr_d;
    logic [NB-1:0]        strb_q, strb_d;
    logic [BUS_WIDTH-1:0] hrdata_q, hrdata_d;
    logic                 rd_first_q, rd_first_d;   // first data-phase cycle of a read

    logic                 win_hit;
    logic [MEM_AW-1:0]    win_idx;
    logic                 range_err;
    logic                 hready;
    logic                 accept;
    logic                 in_err;

    shb_addr_decode #(
        .BUS_ADDR  (BUS_ADDR),
        .BUS_WIDTH (BUS_WIDTH),
        .MEM_AW    (MEM_AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .haddr_i (bus.haddr),
        .hit_o   (win_hit),
        .idx_o   (win_idx)
    );

    assign in_err = (state_q == ERR1) || (state_q == ERR2);

`ifdef SHB_SLAVE_RANGE_CHECK_EN
    assign range_err = ~win_hit;
    assign bus.hresp = in_err ? RESP_ERR : RESP_OK;
`else
    // Memory aliases over the whole address space; the hit is not needed.
    logic unused_win_hit;
    assign unused_win_hit = win_hit;
    assign range_err      = 1'b0;
    assign bus.hresp      = RESP_OK;
`endif

    // Bursts are decoded beat by beat, so hburst carries no information here.
    logic unused_hburst;
    assign unused_hburst = bus.hburst;

    always_comb begin
        hready = 1'b0;
        case (state_q)
            IDLE, ERR2: hready = 1'b1;
            RD, WR:     hready = (wcnt_q == '0);
            default:    hready = 1'b0;
        endcase
    end

    assign bus.hready = hready;
    // Fresh SRAM data is passed straight through on the first data-phase cycle.
    assign bus.hrdata = in_err     ? '0        :
                        rd_first_q ? mem_rdata : hrdata_q;

    assign accept = (bus.htrans == TRANS_ACT) && hready && !rst;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        strb_d     = strb_q;
        hrdata_d   = rd_first_q ? mem_rdata : hrdata_q;
        rd_first_d = 1'b0;
        mem_ce     = 1'b0;
        mem_we     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;

        if ((state_q == RD || state_q == WR) && wcnt_q != '0) begin
            wcnt_d = wcnt_q - 1'b1;
        end

        // Final cycle of a write data phase: hwdata is valid now.
        if (state_q == WR && hready) begin
            mem_ce    = 1'b1;
            mem_we    = strb_q;
            mem_addr  = addr_q;
            mem_wdata = bus.hwdata;
        end

        // Deferred read; the counter is frozen so RAW costs exactly one cycle.
        if (state_q == RAW) begin
            mem_ce     = 1'b1;
            mem_addr   = addr_q;
            rd_first_d = 1'b1;
            state_d    = RD;
        end

        if (state_q == ERR1) begin
            state_d = ERR2;
        end

        if (hready) begin
            if (accept) begin
                wcnt_d = WCNT_W'(WAIT_STATES);
                if (range_err) begin
                    state_d = ERR1;
                end else if (bus.hwrite == '0) begin
                    if (state_q == WR) begin
                        // SRAM port busy with the completing write.
                        state_d = RAW;
                        addr_d  = win_idx;
                    end else begin
                        state_d    = RD;
                        mem_ce     = 1'b1;
                        mem_addr   = win_idx;
                        rd_first_d = 1'b1;
                    end
                end else begin
                    state_d = WR;
                    addr_d  = win_idx;
                    strb_d  = bus.hwrite;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            addr_q     <= '0;
            strb_q     <= '0;
            hrdata_q   <= '0;
            rd_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            addr_q     <= addr_d;
            strb_q     <= strb_d;
            hrdata_q   <= hrdata_d;
            rd_first_q <= rd_first_d;
        end
    end
endmodule

// File: tb/tb_shb_sram_slave.sv
// Self-checking bench for shb_sram_slave: pipelined master, SRAM model, scoreboard.
// WS is the wait-state setting under test and must be at least 1 for the reset case.
// Expected read data, response and data-phase length are queued at address acceptance.
module tb_shb_sram_slave #(
    parameter int WS = 2
);
    localparam logic [31:0] WIN_BYTES = 32'h0000_2000;
`ifdef SHB_SLAVE_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  strb;
        logic [15:0] wdata;
        logic        burst;
    } cmd_t;

    typedef struct packed {
        logic        is_rd;
        logic [15:0] data;
        logic        resp;
        logic [31:0] lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        mem_ce;
    logic [1:0]  mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    shb_sram_slave_if #(.BUS_ADDR(32), .BUS_WIDTH(16)) bus();

    shb_sram_slave #(
        .BUS_ADDR    (32),
        .BUS_WIDTH   (16),
        .MEM_AW      (12),
        .WAIT_STATES (WS),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: synchronous, read data one cycle after mem_ce.
    logic [15:0] sram [0:4095];
    int          we_cnt = 0;
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we[0]) sram[mem_addr][7:0]  = mem_wdata[7:0];
            if (mem_we[1]) sram[mem_addr][15:8] = mem_wdata[15:8];
            if (mem_we != 2'b00) we_cnt++;
            mem_rdata <= sram[mem_addr];
        end
    end

    logic [15:0] ref_mem [0:4095];
    cmd_t        cmdq [$];
    exp_t        sb [$];
    cmd_t        ap;
    logic        ap_vld, dp_vld, last_rdy;
    int          cyc, dp_start, wr_done_cyc, first_acc, done_cyc;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr_exp = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] addr, input logic [1:0] strb,
                        input logic [15:0] wdata, input logic burst);
        cmd_t c;
        c.addr = addr; c.strb = strb; c.wdata = wdata; c.burst = burst;
        cmdq.push_back(c);
    endtask

    // One bus cycle, acting just after the rising edge.
    task automatic step();
        exp_t        e;
        logic [11:0] idx;
        logic        err;
        logic        rdy;
        @(posedge clk); #1;
        cyc++;
        // Address presented last cycle was sampled at this edge.
        if (last_rdy && ap_vld) begin
            idx     = 12'(ap.addr >> 1);
            err     = RANGE_EN && (ap.addr >= WIN_BYTES);
            e.is_rd = (ap.strb == 2'b00);
            e.resp  = err;
            e.data  = (err || !e.is_rd) ? 16'h0 : ref_mem[idx];
            if (err)
                e.lat = 32'd2;
            else if (e.is_rd && wr_done_cyc == cyc - 1)
                e.lat = 32'(WS + 2);
            else
                e.lat = 32'(WS + 1);
            if (!e.is_rd && !err) begin
                if (ap.strb[0]) ref_mem[idx][7:0]  = ap.wdata[7:0];
                if (ap.strb[1]) ref_mem[idx][15:8] = ap.wdata[15:8];
                n_wr_exp++;
            end
            sb.push_back(e);
            if (first_acc < 0) first_acc = cyc - 1;
            dp_vld     = 1'b1;
            dp_start   = cyc;
            bus.hwdata = ap.wdata;
            ap_vld     = 1'b0;
        end
        rdy = bus.hready;
        if (rdy) begin
            if (dp_vld) begin
                e = sb.pop_front();
                check_val("dphase_len", 32'(cyc - dp_start + 1), e.lat);
                check_val("hresp", 32'(bus.hresp), 32'(e.resp));
                if (e.is_rd) check_val("hrdata", 32'(bus.hrdata), 32'(e.data));
                if (!e.is_rd && !e.resp) wr_done_cyc = cyc;
                done_cyc = cyc;
                dp_vld   = 1'b0;
            end
            if (cmdq.size() > 0) begin
                ap          = cmdq.pop_front();
                ap_vld      = 1'b1;
                bus.haddr   = ap.addr;
                bus.hwrite  = ap.strb;
                bus.hburst  = ap.burst;
                bus.htrans  = 1'b1;
            end else begin
                bus.htrans = 1'b0;
                bus.hburst = 1'b0;
            end
        end
        last_rdy = rdy;
    endtask

    task automatic run();
        int guard = 0;
        first_acc = -1;
        while ((cmdq.size() > 0 || ap_vld || dp_vld) && guard < 200) begin
            step();
            guard++;
        end
        check_val("run_bound", 32'(guard < 200), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            sram[i]    = 16'h0;
            ref_mem[i] = 16'h0;
        end
        rst = 1'b1;
        bus.haddr = '0; bus.hwrite = '0; bus.hburst = 1'b0; bus.htrans = 1'b0; bus.hwdata = '0;
        ap_vld = 1'b0; dp_vld = 1'b0; last_rdy = 1'b1;
        cyc = 0; wr_done_cyc = -10; first_acc = -1; done_cyc = 0; dp_start = 0;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_hready",    32'(bus.hready), 32'd1);
        check_val("rst_hresp",     32'(bus.hresp),  32'd0);
        check_val("rst_hrdata",    32'(bus.hrdata), 32'd0);
        check_val("rst_mem_ce",    32'(mem_ce),     32'd0);
        check_val("rst_mem_we",    32'(mem_we),     32'd0);
        check_val("rst_mem_addr",  32'(mem_addr),   32'd0);
        check_val("rst_mem_wdata", 32'(mem_wdata),  32'd0);
        rst = 1'b0;

        // Full write, then an isolated read.
        push(32'h10, 2'b11, 16'hBEEF, 1'b0); run();
        push(32'h10, 2'b00, 16'h0, 1'b0);    run();

        // Upper-byte write merges with existing contents.
        push(32'h10, 2'b10, 16'h1234, 1'b0); run();
        push(32'h10, 2'b00, 16'h0, 1'b0);    run();

        // Write immediately followed by read of the same word.
        push(32'h20, 2'b11, 16'hCAFE, 1'b0);
        push(32'h20, 2'b00, 16'h0, 1'b0);
        run();

        // Back-to-back writes, then a 4-beat read burst.
        for (int i = 0; i < 4; i++) push(32'h30 + 32'(2 * i), 2'b11, 16'hA000 + 16'(i), 1'b0);
        run();
        for (int i = 0; i < 4; i++) push(32'h30 + 32'(2 * i), 2'b00, 16'h0, 1'b1);
        run();
        check_val("burst_cycles", 32'(done_cyc - first_acc), 32'(4 * (WS + 1)));

        // Read, low-byte write, read-after-write in one pipeline.
        push(32'h30, 2'b00, 16'h0, 1'b0);
        push(32'h32, 2'b01, 16'h00FF, 1'b0);
        push(32'h32, 2'b00, 16'h0, 1'b0);
        run();

        // Outside the window: error response or alias onto word 0.
        push(32'h0000, 2'b11, 16'h1111, 1'b0);
        push(32'h4000, 2'b11, 16'h2222, 1'b0);
        push(32'h0000, 2'b00, 16'h0, 1'b0);
        push(32'h4000, 2'b00, 16'h0, 1'b0);
        run();

        // Reset during write wait states drops the write.
        @(posedge clk); #1;
        bus.haddr = 32'h10; bus.hwrite = 2'b11; bus.htrans = 1'b1;
        @(posedge clk); #1;
        bus.htrans = 1'b0; bus.hwdata = 16'h5555;
        check_val("wr_wait_hready", 32'(bus.hready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_val("rst_mid_hready", 32'(bus.hready), 32'd1);
        check_val("rst_mid_mem_we", 32'(mem_we),     32'd0);
        check_val("rst_mid_hresp",  32'(bus.hresp),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_rdy = 1'b1; ap_vld = 1'b0; dp_vld = 1'b0;
        push(32'h10, 2'b00, 16'h0, 1'b0);
        run();

        repeat (2) @(posedge clk);
        check_val("mem_we_pulses", 32'(we_cnt), 32'(n_wr_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/shb_sram_slave.md
# shb_sram_slave

Shrinked-AHB responder fronting a single-port synchronous SRAM. It terminates the CPU-side bus master (haddr/hwrite/hburst/htrans/hwdata in; hready/hresp/hrdata out) and serves pipelined address/data-phase transfers. It inserts programmable wait states, resolves the write-data-phase/read-address-phase port conflict, and optionally returns the two-cycle error response for out-of-window addresses. It sits on the system bus as the main RAM target behind the core's bus unit.

## Interface
- BUS_ADDR, 32, haddr width.
- BUS_WIDTH, 16, data width (8 or 16); NB = BUS_WIDTH/8 byte lanes.
- MEM_AW, 12, SRAM word-address width.
- WAIT_STATES, 0, extra hready-low cycles per data phase (0..7).
- BASE_ADDR, 32'h0000_0000, window base, aligned to the window size (NB·2^MEM_AW bytes).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- haddr  in  BUS_ADDR  byte address, address phase.
- hwrite  in  NB  byte write strobes; all-zero = read.
- hburst  in  1  beat belongs to an incrementing burst (informational only).
- htrans  in  1  1 = active transfer, 0 = idle.
- hwdata  in  BUS_WIDTH  write data, data phase.
- hready  out  1  1 = data phase completes / address sampled.
- hresp  out  1  1 = error response.
- hrdata  out  BUS_WIDTH  read data, valid in the final data-phase cycle.
- mem_ce  out  1  SRAM access enable.
- mem_we  out  NB  SRAM byte write enables.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  BUS_WIDTH  SRAM write data.
- mem_rdata  in  BUS_WIDTH  SRAM read data, one cycle after mem_ce.

## Operation
- The address phase is accepted when htrans=1 and hready=1. Word index = haddr[MEM_AW+log2(NB)-1 : log2(NB)].
- FSM states: IDLE, RD, WR, RAW, ERR1, ERR2.
- IDLE: no data phase outstanding.
- RD: a read is accepted from IDLE, RD or ERR2. The SRAM read is issued combinationally in the address-phase cycle, and mem_rdata is captured into the hrdata hold register.
- WR: the address, strobes and index are latched. The SRAM write is issued in the final data-phase cycle using hwdata.
- RAW: entered when a read address is accepted in the same cycle a WR data phase completes. The SRAM read is deferred one cycle, adding exactly one wait state.
- A write accepted during a WR completion needs no stall: its SRAM write happens later.
- The wait counter loads WAIT_STATES on each accepted transfer. hready=0 until the counter reaches 0.
- hburst does not alter behaviour. Each beat's address is decoded independently.
- htrans=0 with hready=1 results in IDLE, no SRAM access, hready=1, hresp=0.
- Reset values: hready=1, hresp=0, hrdata=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, FSM in IDLE, wait counter 0.
- Reset mid-transfer: all outputs revert asynchronously and the pending write is dropped.

## Timing
- Read with WAIT_STATES=W: address at cycle N, hready=0 for cycles N+1..N+W, hrdata valid with hready=1 at N+1+W.
- Write: hwdata sampled and mem_we asserted in cycle N+1+W, the same cycle hready=1.
- RAW adds exactly one cycle to the read data phase.
- Back-to-back reads with W=0 sustain one beat per cycle.
- Error response: ERR1 has hready=0, hresp=1. ERR2 has hready=1, hresp=1. An address accepted during ERR2 is processed normally.
- Errored writes never assert mem_we. Errored reads return hrdata=0.

## Configuration
- SHB_SLAVE_RANGE_CHECK_EN defined: haddr outside [BASE_ADDR, BASE_ADDR + NB·2^MEM_AW) produces ERR1→ERR2 with no SRAM access.
- SHB_SLAVE_RANGE_CHECK_EN undefined: upper address bits are ignored, the memory aliases across the whole address space, and hresp is tied to 0.

## Structure
- Shared package shb_pkg holds:
  - the state enum (IDLE, RD, WR, RAW, ERR1, ERR2);
  - htrans/hresp encodings (TRANS_IDLE=0, TRANS_ACT=1, RESP_OK=0, RESP_ERR=1);
  - the wait-counter width constant (3).
- One sub-module, shb_addr_decode: window hit and word-index extraction, shared with future shrinked-AHB targets.

## Test plan
All scenarios use BUS_WIDTH=16, MEM_AW=12, BASE_ADDR=0.
- Write 0xBEEF to 0x0010 (hwrite=2'b11), then read 0x0010 with W=0 → hrdata=0xBEEF one cycle after the read address; hready stays 1 throughout.
- Byte write 0x12 via hwrite=2'b10 to 0x0010 holding 0xBEEF → a subsequent read returns 0x12EF.
- Write 0x0020 immediately followed by read 0x0020 → one wait state (RAW); hrdata=new data; exactly one mem_we pulse before mem_ce for the read.
- WAIT_STATES=3, read → hready low exactly 3 cycles, then data; a 4-beat burst (hburst=1) of 0x0030..0x0036 completes in 16 cycles.
- With SHB_SLAVE_RANGE_CHECK_EN, write to 0x0000_4000 → hready=0/hresp=1 then hready=1/hresp=1, no mem_we; without the macro, the same write lands at word 0.
- Assert rst during WR wait states (W=2) → hready=1, mem_we=0 immediately; a post-reset read of that address shows the old data.
